// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states and the channel that owns the memory.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  typedef enum logic {
    CH_DATA  = 1'b0,
    CH_INSTR = 1'b1
  } channel_t;

endpackage

// File: rtl/memory_arbiter.sv
// Shares one single-port memory between a data port and an instruction-fetch port, one transaction at a time.
// Success pulses MEM_LATENCY+1 cycles after the request is sampled; requesters hold their request until Success.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dataMemoryReadEnable,
  input  logic                  dataMemoryWriteEnable,
  input  logic [ADDR_WIDTH-1:0] dataMemoryAddress,
  input  logic [DATA_WIDTH-1:0] dataMemoryDataIn,
  input  logic                  instructionMemoryReadEnable,
  input  logic [ADDR_WIDTH-1:0] instructionMemoryAddress,
  output logic                  dataMemorySuccess,
  output logic                  instructionMemorySuccess,
  output logic [DATA_WIDTH-1:0] dataMemoryDataOut,
  output logic [DATA_WIDTH-1:0] instructionMemoryDataOut,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic                  memWriteEnable,
  output logic                  memReadEnable,
  output logic [DATA_WIDTH-1:0] memDataIn,
  input  logic [DATA_WIDTH-1:0] memDataOut,
  output logic                  busy
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(MEM_LATENCY - 1);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

  state_t           state;
  channel_t         gnt_ch;
  logic             gnt_wr;
  logic [CNT_W-1:0] acc_cnt;
  logic [STV_W-1:0] starve_cnt;

  logic                  data_req;
  logic                  instr_req;
  logic                  pick_instr;
  channel_t              nxt_ch;
  logic                  nxt_wr;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [DATA_WIDTH-1:0] nxt_data;

  assign data_req   = dataMemoryReadEnable | dataMemoryWriteEnable;
  assign instr_req  = instructionMemoryReadEnable;
  assign pick_instr = instr_req && (!data_req || starve_cnt == STARVE_MAX);

  // A simultaneous read+write on the data port is a write; reads drive zero write data.
  always_comb begin
    nxt_ch   = pick_instr ? CH_INSTR : CH_DATA;
    nxt_wr   = !pick_instr && dataMemoryWriteEnable;
    nxt_addr = pick_instr ? instructionMemoryAddress : dataMemoryAddress;
    nxt_data = nxt_wr ? dataMemoryDataIn : '0;
  end

  // The mem* output registers double as the latched transaction, so the memory
  // sees nothing but frozen values for the whole ACCESS window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                    <= IDLE;
      gnt_ch                   <= CH_DATA;
      gnt_wr                   <= 1'b0;
      acc_cnt                  <= '0;
      starve_cnt               <= '0;
      busy                     <= 1'b0;
      dataMemorySuccess        <= 1'b0;
      instructionMemorySuccess <= 1'b0;
      dataMemoryDataOut        <= '0;
      instructionMemoryDataOut <= '0;
      memAddress               <= '0;
      memWriteEnable           <= 1'b0;
      memReadEnable            <= 1'b0;
      memDataIn                <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (data_req || instr_req) begin
            state          <= ACCESS;
            acc_cnt        <= '0;
            busy           <= 1'b1;
            gnt_ch         <= nxt_ch;
            gnt_wr         <= nxt_wr;
            memAddress     <= nxt_addr;
            memDataIn      <= nxt_data;
            memWriteEnable <= nxt_wr;
            memReadEnable  <= !nxt_wr;
            if (pick_instr) begin
              starve_cnt <= '0;
            end else if (instr_req && starve_cnt != STARVE_MAX) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        ACCESS: begin
          if (acc_cnt == LAST_BEAT) begin
            state          <= RESPOND;
            memAddress     <= '0;
            memDataIn      <= '0;
            memWriteEnable <= 1'b0;
            memReadEnable  <= 1'b0;
            if (!gnt_wr) begin
              if (gnt_ch == CH_INSTR) begin
                instructionMemoryDataOut <= memDataOut;
              end else begin
                dataMemoryDataOut <= memDataOut;
              end
            end
            dataMemorySuccess        <= (gnt_ch == CH_DATA);
            instructionMemorySuccess <= (gnt_ch == CH_INSTR);
          end else begin
            acc_cnt <= acc_cnt + 1'b1;
          end
        end
        RESPOND: begin
          state                    <= IDLE;
          busy                     <= 1'b0;
          dataMemorySuccess        <= 1'b0;
          instructionMemorySuccess <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: a latency-1 instance checked every cycle against a transaction-window
// model under directed and random traffic, plus a latency-3 instance with directed checks.
`timescale 1ns/1ps
module tb_memory_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;
  localparam int SLIM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3;

  logic          d_re, d_we, i_re;
  logic [AW-1:0] d_addr, i_addr, mem_addr;
  logic [DW-1:0] d_din, d_dout, i_dout, mem_din, mem_dout;
  logic          d_ok, i_ok, busy, mem_we, mem_re;

  logic          d_re3, d_we3, i_re3;
  logic [AW-1:0] d_addr3, i_addr3, mem_addr3;
  logic [DW-1:0] d_din3, d_dout3, i_dout3, mem_din3, mem_dout3;
  logic          d_ok3, i_ok3, busy3, mem_we3, mem_re3;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  bit mdl_on = 1'b0;

  memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)) u_dut (
    .clk(clk), .reset(rst1),
    .dataMemoryReadEnable(d_re), .dataMemoryWriteEnable(d_we),
    .dataMemoryAddress(d_addr), .dataMemoryDataIn(d_din),
    .instructionMemoryReadEnable(i_re), .instructionMemoryAddress(i_addr),
    .dataMemorySuccess(d_ok), .instructionMemorySuccess(i_ok),
    .dataMemoryDataOut(d_dout), .instructionMemoryDataOut(i_dout),
    .memAddress(mem_addr), .memWriteEnable(mem_we), .memReadEnable(mem_re),
    .memDataIn(mem_din), .memDataOut(mem_dout), .busy(busy));

  memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT3), .STARVE_LIMIT(SLIM)) u_dut3 (
    .clk(clk), .reset(rst3),
    .dataMemoryReadEnable(d_re3), .dataMemoryWriteEnable(d_we3),
    .dataMemoryAddress(d_addr3), .dataMemoryDataIn(d_din3),
    .instructionMemoryReadEnable(i_re3), .instructionMemoryAddress(i_addr3),
    .dataMemorySuccess(d_ok3), .instructionMemorySuccess(i_ok3),
    .dataMemoryDataOut(d_dout3), .instructionMemoryDataOut(i_dout3),
    .memAddress(mem_addr3), .memWriteEnable(mem_we3), .memReadEnable(mem_re3),
    .memDataIn(mem_din3), .memDataOut(mem_dout3), .busy(busy3));

  function automatic logic [31:0] init_val(input logic [5:0] i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  function automatic logic [31:0] raddr();
    logic [5:0] w;
    w = 6'($urandom_range(0, 63));
    return {24'h0, w, 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // 64-word memory behind the latency-1 instance; unwritten words read a known pattern.
  logic [DW-1:0] tbmem [64];
  bit   [63:0]   tbmem_v;
  always @(posedge clk) begin
    if (mem_we) begin
      tbmem[mem_addr[7:2]]   <= mem_din;
      tbmem_v[mem_addr[7:2]] <= 1'b1;
    end
  end
  assign mem_dout = !mem_re ? 32'hDEAD_BEEF :
                    tbmem_v[mem_addr[7:2]] ? tbmem[mem_addr[7:2]] : init_val(mem_addr[7:2]);

  // Latency-3 memory: data is valid only once the read has been held for three cycles.
  int stab3 = 0;
  always @(posedge clk) stab3 <= mem_re3 ? stab3 + 1 : 0;
  assign mem_dout3 = (mem_re3 && stab3 >= LAT3 - 1) ? (32'h3000_0000 | mem_addr3) : 32'hBAD0_BAD0;

  // Reference model: a granted transaction at cycle g occupies the memory in cycles
  // g+1..g+LAT, completes at g+LAT+1, and the arbiter accepts again from g+LAT+2.
  bit            have = 1'b0;
  int unsigned   g = 0;
  bit            t_ch, t_wr;
  logic [31:0]   t_addr, t_din, t_rd;
  logic [31:0]   e_dout [2];
  int            starve = 0;
  logic [31:0]   mm [64];
  bit   [63:0]   mm_v;

  always @(negedge clk) begin : model
    bit in_acc, in_resp, dq, pick_i;
    logic [5:0] idx;
    cyc++;
    if (have && cyc >= g + LAT + 2) have = 1'b0;
    in_acc  = have && cyc > g && cyc <= g + LAT;
    in_resp = have && cyc == g + LAT + 1;
    if (in_resp && !t_wr) e_dout[t_ch] = t_rd;
    if (mdl_on) begin
      chk("busy", 32'(busy), 32'(have && cyc > g));
      chk("data_success", 32'(d_ok), 32'(in_resp && !t_ch));
      chk("instr_success", 32'(i_ok), 32'(in_resp && t_ch));
      chk("mem_read_en", 32'(mem_re), 32'(in_acc && !t_wr));
      chk("mem_write_en", 32'(mem_we), 32'(in_acc && t_wr));
      chk("mem_addr", mem_addr, in_acc ? t_addr : 32'h0);
      chk("mem_data_in", mem_din, (in_acc && t_wr) ? t_din : 32'h0);
      chk("data_dout", d_dout, e_dout[0]);
      chk("instr_dout", i_dout, e_dout[1]);
    end
    if (rst1) begin
      have = 1'b0;
      e_dout[0] = '0;
      e_dout[1] = '0;
      starve = 0;
    end else if (!have && (d_re || d_we || i_re)) begin
      dq = d_re || d_we;
      pick_i = i_re && (!dq || starve == SLIM);
      if (pick_i) begin
        t_ch = 1'b1; t_wr = 1'b0; t_addr = i_addr; t_din = '0; starve = 0;
      end else begin
        t_ch = 1'b0; t_wr = d_we; t_addr = d_addr; t_din = d_din;
        if (i_re && starve < SLIM) starve++;
      end
      idx = t_addr[7:2];
      if (t_wr) begin
        mm[idx] = t_din;
        mm_v[idx] = 1'b1;
      end else begin
        t_rd = mm_v[idx] ? mm[idx] : init_val(idx);
      end
      g = cyc;
      have = 1'b1;
    end
  end

  int wcnt = 0;

  task automatic txn(input bit ch, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] dd, output int lat);
    lat = -1;
    if (ch) begin
      i_re = 1'b1; i_addr = a;
    end else begin
      d_re = rd; d_we = wr; d_addr = a; d_din = dd;
    end
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (mem_we) wcnt++;
      if (ch ? i_ok : d_ok) begin
        lat = k;
        break;
      end
    end
    d_re = 1'b0; d_we = 1'b0; i_re = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin : stim
    int lat, nsucc, rcnt, bad, okcnt, op;
    logic [9:0] order;
    bit d_act, i_act;

    rst1 = 1'b1; rst3 = 1'b1;
    d_re = 0; d_we = 0; i_re = 0; d_addr = '0; i_addr = '0; d_din = '0;
    d_re3 = 0; d_we3 = 0; i_re3 = 0; d_addr3 = '0; i_addr3 = '0; d_din3 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst1 = 1'b0; rst3 = 1'b0; mdl_on = 1'b1;

    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_re", 32'(mem_re), 32'h0);
    chk("rst_data_dout", d_dout, 32'h0);
    chk("rst3_busy", 32'(busy3), 32'h0);
    chk("rst3_success", 32'({d_ok3, i_ok3}), 32'h0);

    // Instruction fetch of a word written through the data port.
    txn(1'b0, 1'b0, 1'b1, 32'h10, 32'hCAFE_BABE, lat);
    txn(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, lat);
    chk("fetch_latency", 32'(lat), 32'd2);
    chk("fetch_data", i_dout, 32'hCAFE_BABE);

    wcnt = 0;
    txn(1'b0, 1'b0, 1'b1, 32'h40, 32'h1234_5678, lat);
    chk("write_pulse_cycles", 32'(wcnt), 32'd1);
    txn(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, lat);
    chk("read_latency", 32'(lat), 32'd2);
    chk("read_back", d_dout, 32'h1234_5678);

    // Read and write together: a write, and the data output keeps its old value.
    txn(1'b0, 1'b1, 1'b1, 32'h44, 32'hAAAA_5555, lat);
    chk("rw_keeps_dout", d_dout, 32'h1234_5678);
    txn(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, lat);
    chk("rw_was_write", d_dout, 32'hAAAA_5555);

    // Both ports held: expect D,D,D,D,I,D,D,D,D,I (I recorded as 1).
    d_re = 1'b1; d_addr = 32'h20; i_re = 1'b1; i_addr = 32'h24;
    order = '0; nsucc = 0;
    for (int k = 0; k < 100 && nsucc < 10; k++) begin
      @(posedge clk); #1;
      if (d_ok || i_ok) begin
        order = {order[8:0], i_ok};
        nsucc++;
      end
    end
    d_re = 1'b0; i_re = 1'b0;
    @(posedge clk); #1;
    chk("grant_count", 32'(nsucc), 32'd10);
    chk("grant_order", 32'(order), 32'(10'b00001_00001));

    // Latency 3: request address changes mid-access must not reach the memory.
    d_re3 = 1'b1; d_addr3 = 32'h80;
    lat = -1; rcnt = 0; bad = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) d_addr3 = 32'h99C;
      if (mem_re3) begin
        rcnt++;
        if (mem_addr3 !== 32'h80) bad++;
      end
      if (d_ok3) begin
        lat = k;
        break;
      end
    end
    d_re3 = 1'b0;
    @(posedge clk); #1;
    chk("l3_latency", 32'(lat), 32'd4);
    chk("l3_read_cycles", 32'(rcnt), 32'd3);
    chk("l3_addr_stable", 32'(bad), 32'd0);
    chk("l3_read_data", d_dout3, 32'h3000_0080);

    // Latency 3: reset in the second access cycle aborts silently.
    d_re3 = 1'b1; d_addr3 = 32'h84;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("l3_busy_before_rst", 32'({busy3, mem_re3}), 32'h3);
    rst3 = 1'b1; d_re3 = 1'b0;
    @(posedge clk); #1;
    chk("l3_rst_busy", 32'(busy3), 32'h0);
    chk("l3_rst_mem", {mem_addr3[29:0], mem_re3, mem_we3}, 32'h0);
    chk("l3_rst_dout", d_dout3, 32'h0);
    chk("l3_rst_success", 32'({d_ok3, i_ok3}), 32'h0);
    rst3 = 1'b0;
    okcnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (d_ok3 || i_ok3) okcnt++;
    end
    chk("l3_no_late_success", 32'(okcnt), 32'd0);

    // Random traffic on the latency-1 instance, with one reset partway through.
    d_act = 1'b0; i_act = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (rst1) rst1 = 1'b0;
      if (d_ok) d_act = 1'b0;
      if (i_ok) i_act = 1'b0;
      if (n == 1500) begin
        rst1 = 1'b1; d_act = 1'b0; i_act = 1'b0;
      end
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1'b1;
        op = int'($urandom_range(0, 3));
        d_re = (op != 2);
        d_we = (op >= 2);
        d_addr = raddr();
        d_din = $urandom();
      end
      if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act = 1'b1;
        i_re = 1'b1;
        i_addr = raddr();
      end
      if (!d_act) begin
        d_re = 1'b0; d_we = 1'b0;
      end
      if (!i_act) i_re = 1'b0;
      if (busy && $urandom_range(0, 1) == 1) begin
        d_addr = raddr(); d_din = $urandom(); i_addr = raddr();
      end
    end
    d_re = 1'b0; d_we = 1'b0; i_re = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of all data buses.
REQ-002 Parameter ADDR_WIDTH, 32, width of all address buses.
REQ-003 Parameter MEM_LATENCY, 1, cycles the memory needs with inputs held stable before read data is valid; legal range >=1.
REQ-004 Parameter STARVE_LIMIT, 4, consecutive data grants tolerated while an instruction request waits; legal range >=1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 dataMemoryReadEnable  input  1  data-side read request, held until dataMemorySuccess.
REQ-008 dataMemoryWriteEnable  input  1  data-side write request, held until dataMemorySuccess.
REQ-009 dataMemoryAddress  input  ADDR_WIDTH  data-side address.
REQ-010 dataMemoryDataIn  input  DATA_WIDTH  data-side write data.
REQ-011 instructionMemoryReadEnable  input  1  instruction fetch request, held until instructionMemorySuccess.
REQ-012 instructionMemoryAddress  input  ADDR_WIDTH  fetch address.
REQ-013 dataMemorySuccess / instructionMemorySuccess  output  1 each  one-cycle completion pulse.
REQ-014 dataMemoryDataOut / instructionMemoryDataOut  output  DATA_WIDTH each  registered read data, held until that channel's next read completes.
REQ-015 memAddress  output  ADDR_WIDTH; memWriteEnable, memReadEnable  output  1; memDataIn  output  DATA_WIDTH  -- single-port memory drive.
REQ-016 memDataOut  input  DATA_WIDTH  memory read data.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS, RESPOND; one transaction outstanding at a time.
REQ-019 In IDLE with any request, the block SHALL grant one channel, latch its address/data/op into internal registers, clear the access counter and enter ACCESS next cycle.
REQ-020 Grant rule: data channel wins, except instruction wins when starve count == STARVE_LIMIT and an instruction request is pending.
REQ-021 Starve count SHALL increment (saturating at STARVE_LIMIT) on each data grant while instruction request is pending, and clear to 0 on each instruction grant.
REQ-022 dataMemoryWriteEnable and dataMemoryReadEnable both high SHALL be treated as a write; read data output unchanged.
REQ-023 In ACCESS, mem* outputs SHALL be driven solely from latched registers, stable for exactly MEM_LATENCY cycles; outside ACCESS memReadEnable=memWriteEnable=0, memAddress=0, memDataIn=0.
REQ-024 On the last ACCESS cycle of a read, memDataOut SHALL be captured into the granted channel's DataOut register; then enter RESPOND.
REQ-025 In RESPOND, exactly the granted channel's Success SHALL be high for one cycle; next state IDLE.
REQ-026 Latency: request first sampled in IDLE at cycle t -> Success high at cycle t+MEM_LATENCY+1; back-to-back throughput one transaction per MEM_LATENCY+2 cycles.
REQ-027 Request inputs changing after grant SHALL NOT affect the in-flight transaction.
REQ-028 Both Success outputs SHALL never be high in the same cycle.

Reset
REQ-029 On reset: state IDLE, starve count 0, counter 0, all outputs 0, both DataOut registers 0.
REQ-030 Reset during ACCESS or RESPOND SHALL abort the transaction with no Success pulse and mem enables low in the following cycle.

Structure
REQ-031 Package memory_arbiter_pkg SHALL hold the state enum (IDLE/ACCESS/RESPOND) and channel enum (CH_DATA/CH_INSTR).
REQ-032 Single module, no sub-modules; the Memory instance lives outside and is wired to mem* ports.
REQ-033 Counters sized $clog2(MEM_LATENCY+1) and $clog2(STARVE_LIMIT+1).

Verification
REQ-034 Instruction read addr 0x10, mem returns 0xCAFEBABE, MEM_LATENCY=1 -> instructionMemorySuccess at t+2, instructionMemoryDataOut=0xCAFEBABE.
REQ-035 Data write addr 0x40 data 0x12345678, then data read 0x40 -> second dataMemorySuccess with dataMemoryDataOut=0x12345678; memWriteEnable high exactly one cycle.
REQ-036 Both requests held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-037 MEM_LATENCY=3, read request -> mem inputs stable 3 cycles, Success at t+4; request address changed mid-ACCESS has no effect.
REQ-038 Reset asserted in second ACCESS cycle -> no Success pulse, busy=0 and all outputs 0 next cycle.
REQ-039 Read and write asserted together -> treated as write; dataMemoryDataOut retains prior value.
